// File: rtl/game_sequencer.sv
// Memory-game sequencer: shows an LFSR-derived LED pattern, then checks the player's keys.
// display codes: 0 StAy, 1 PLAy, 2 PASS, 3 FAIL.
module game_sequencer #(
    parameter int SEQ_LEN       = 4,
    parameter int STEP_TICKS    = 25000000,
    parameter int GAP_TICKS     = 12500000,
    parameter int TIMEOUT_TICKS = 250000000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [3:0] key,
    output logic [1:0] display,
    output logic [3:0] led
);

    localparam int MAX_A = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int MAX_T = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int SW    = 2 * SEQ_LEN;

    localparam logic [TW-1:0] STEP_END = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]    LAST     = 4'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_INPUT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [1:0]    display_n;
    logic [3:0]    led_n;
    logic [3:0]    idx, idx_n, idx_inc;
    logic [TW-1:0] timer, timer_n;
    logic          gap, gap_n;
    logic [31:0]   seq, seq_n;
    logic [31:0]   lfsr, lfsr_n;
    logic          start_q;
    logic [3:0]    key_q;
    logic          start_e;
    logic [3:0]    key_e;

    // Two bits per step; step i lives at seq[2i+1:2i].
    function automatic logic [3:0] step_led(input logic [31:0] s, input logic [3:0] i);
        logic [1:0] v;
        v = s[{i, 1'b0} +: 2];
        return 4'b0001 << v;
    endfunction

    assign start_e = start & ~start_q;
    assign key_e   = key & ~key_q;
    assign idx_inc = idx + 4'd1;
    assign lfsr_n  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    always_comb begin
        state_n   = state;
        display_n = display;
        led_n     = led;
        idx_n     = idx;
        timer_n   = timer;
        gap_n     = gap;
        seq_n     = seq;
        unique case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start_e) begin
                    state_n   = S_SHOW;
                    display_n = 2'd0;
                    seq_n     = 32'(lfsr[SW-1:0]);
                    led_n     = 4'b0001 << lfsr[1:0];
                    idx_n     = 4'd0;
                    timer_n   = '0;
                    gap_n     = 1'b0;
                end
            end
            S_SHOW: begin
                if (!gap) begin
                    if (timer == STEP_END) begin
                        gap_n   = 1'b1;
                        timer_n = '0;
                        led_n   = 4'd0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end else if (timer == GAP_END) begin
                    timer_n = '0;
                    if (idx != LAST) begin
                        idx_n = idx_inc;
                        gap_n = 1'b0;
                        led_n = step_led(seq, idx_inc);
                    end else begin
                        state_n   = S_INPUT;
                        display_n = 2'd1;
                        idx_n     = 4'd0;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_INPUT: begin
                // A key event beats a coincident timeout.
                if (key_e != 4'd0) begin
                    if (key_e == step_led(seq, idx)) begin
                        timer_n = '0;
                        if (idx == LAST) begin
                            state_n   = S_PASS;
                            display_n = 2'd2;
                        end else begin
                            idx_n = idx_inc;
                        end
                    end else begin
                        state_n   = S_FAIL;
                        display_n = 2'd3;
                    end
                end else if (timer == TO_END) begin
                    state_n   = S_FAIL;
                    display_n = 2'd3;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n   = S_IDLE;
                display_n = 2'd0;
                led_n     = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= S_IDLE;
            display <= 2'd0;
            led     <= 4'd0;
            idx     <= 4'd0;
            timer   <= '0;
            gap     <= 1'b0;
            seq     <= 32'd0;
            start_q <= 1'b0;
            key_q   <= 4'd0;
            lfsr    <= 32'h0000_0001;
        end else begin
            state   <= state_n;
            display <= display_n;
            led     <= led_n;
            idx     <= idx_n;
            timer   <= timer_n;
            gap     <= gap_n;
            seq     <= seq_n;
            start_q <= start;
            key_q   <= key;
            lfsr    <= lfsr_n;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer against a round-level reference model.
module tb_game_sequencer;

    localparam int SL = 4;
    localparam int ST = 4;
    localparam int GT = 2;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] key = 4'd0;
    logic [1:0] display;
    logic [3:0] led;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_lfsr = 32'h1;
    logic [31:0] cap_pre = 32'h1;

    always #5 clk = ~clk;

    game_sequencer #(
        .SEQ_LEN(SL),
        .STEP_TICKS(ST),
        .GAP_TICKS(GT),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .key(key),
        .display(display),
        .led(led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [3:0] want_led(input logic [7:0] s, input int i);
        int v;
        v = int'((s >> (2 * i)) & 8'd3);
        return 4'(1 << v);
    endfunction

    // One clock; the model LFSR tracks every edge, cap_pre is its pre-edge value.
    task automatic tick();
        logic [31:0] pre;
        pre = m_lfsr;
        @(posedge clk);
        cap_pre = pre;
        m_lfsr = nrst ? lfsr_step(pre) : 32'h1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(output logic [7:0] s);
        start = 1'b1;
        tick();
        s = cap_pre[7:0];
        start = 1'b0;
    endtask

    task automatic run_show(input logic [7:0] s, input int steps);
        for (int i = 0; i < steps; i++) begin
            for (int c = 0; c < ST; c++) begin
                check($sformatf("show_led%0d", i), led, want_led(s, i));
                check("show_disp", display, 0);
                tick();
            end
            for (int c = 0; c < GT; c++) begin
                check("gap_led", led, 0);
                tick();
            end
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [1:0] want);
        key = k;
        tick();
        check("press_disp", display, want);
        check("press_led", led, 0);
        repeat ($urandom_range(0, 2)) tick();
        key = 4'd0;
        repeat ($urandom_range(1, 3)) tick();
        check("hold_disp", display, want);
    endtask

    task automatic play_all(input logic [7:0] s);
        for (int i = 0; i < SL; i++)
            press(want_led(s, i), (i == SL - 1) ? 2'd2 : 2'd1);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] s1;
        logic [3:0] w;
        int d;
        int p;

        // Reset with start held: one round only
        nrst = 1'b0;
        start = 1'b1;
        idle(3);
        check("rst_disp", display, 0);
        check("rst_led", led, 0);
        nrst = 1'b1;
        tick();
        s = cap_pre[7:0];
        run_show(s, SL);
        check("input_disp", display, 1);
        play_all(s);
        idle(3);
        check("held_start", display, 2);
        start = 1'b0;
        idle(2);

        // Random rounds
        for (int r = 0; r < 8; r++) begin
            idle($urandom_range(0, 4));
            do_start(s);
            run_show(s, SL);
            check("input_disp", display, 1);
            if ($urandom_range(0, 1) == 0) begin
                play_all(s);
            end else begin
                p = $urandom_range(0, SL - 1);
                for (int i = 0; i < p; i++)
                    press(want_led(s, i), 2'd1);
                do w = 4'($urandom_range(1, 15)); while (w == want_led(s, p));
                press(w, 2'd3);
            end
            check("end_led", led, 0);
        end

        // Correct, correct, wrong
        do_start(s);
        run_show(s, SL);
        press(want_led(s, 0), 2'd1);
        press(want_led(s, 1), 2'd1);
        w = want_led(s, 2);
        press({w[2:0], w[3]}, 2'd3);

        // Two keys at once
        do_start(s);
        run_show(s, SL);
        press(4'b0011, 2'd3);

        // Timeout with no key
        do_start(s);
        run_show(s, SL);
        check("to_entry", display, 1);
        idle(TO - 1);
        check("to_19", display, 1);
        tick();
        check("to_20", display, 3);

        // A correct key restarts the timeout count
        do_start(s);
        run_show(s, SL);
        idle(9);
        key = want_led(s, 0);
        tick();
        check("to_key", display, 1);
        key = 4'd0;
        idle(TO - 1);
        check("to_restart_19", display, 1);
        tick();
        check("to_restart_20", display, 3);

        // Reset mid-SHOW, then replay from the same offset
        nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
        d = $urandom_range(0, 5);
        idle(d);
        do_start(s1);
        run_show(s1, 1);
        check("mid_led", led, want_led(s1, 1));
        nrst = 1'b0;
        tick();
        check("mid_rst_led", led, 0);
        check("mid_rst_disp", display, 0);
        tick();
        nrst = 1'b1;
        idle(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_show(s1, SL);
        check("replay_disp", display, 1);
        play_all(s1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
